truth_table_sweeper: RTL

Sequential stimulus-and-capture stage placed around the 3-input truth-table primitive. It replaces the hand-written test sequence that drove the primitive.
- Drives every input combination onto the primitive's A/B/C pins in ascending minterm order.
- Samples the primitive's output X for each combination.
- Builds the observed truth vector and compares it against an expected vector.
- Reports pass/fail, a per-minterm mismatch mask and a mismatch count.

---
 rtl/truth_table_sweeper.sv | 103 ++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - steps A/B/C through every minterm, samples X, scores it against EXPECTED
module truth_table_sweeper #(
   parameter int                  N_IN          = 3,
   parameter int                  SETTLE_CYCLES = 2,
   parameter logic [2**N_IN-1:0]  EXPECTED      = 8'hD5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [N_IN-1:0]      abc_out,
   input  logic                 x_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2**N_IN-1:0]   captured,
   output logic [2**N_IN-1:0]   mismatch,
   output logic [N_IN:0]        fail_count
);

   localparam int                W        = 2**N_IN;
   localparam int                CW       = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [CW-1:0]     CNT_LOAD = CW'(SETTLE_CYCLES);
   localparam logic [N_IN-1:0]   LAST     = N_IN'(W - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state;
   logic [N_IN-1:0]   index;
   logic [CW-1:0]     cnt;
   logic              mis_now;
   logic [N_IN:0]     fail_next;

   // Case-inequality so an undriven or unknown X is scored as a mismatch in simulation.
   always_comb begin
      mis_now   = (x_in !== EXPECTED[index]);
      fail_next = fail_count + {{N_IN{1'b0}}, mis_now};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         index      <= '0;
         cnt        <= '0;
         abc_out    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         captured   <= '0;
         mismatch   <= '0;
         fail_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= SETTLE;
                  busy       <= 1'b1;
                  index      <= '0;
                  abc_out    <= '0;
                  cnt        <= CNT_LOAD;
                  captured   <= '0;
                  mismatch   <= '0;
                  fail_count <= '0;
                  pass       <= 1'b0;
               end
            end
            SETTLE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  captured[index] <= x_in;
                  mismatch[index] <= mis_now;
                  fail_count      <= fail_next;
                  if (index == LAST) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (fail_next == '0);
                  end else begin
                     index   <= index + 1'b1;
                     abc_out <= index + 1'b1;
                     cnt     <= CNT_LOAD;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
